// File: rtl/cpu_int_ctrl.sv
// Interrupt/reset entry controller: picks the winning source, injects the
// vector fetch instruction into the front end and sequences the pipeline holds.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_RESET    | held by a_rst; leaves for VECTOR on the first edge after
// S_VECTOR   | injected instruction/argument presented to the front end
// S_SKIP     | one issue slot consumed after the injected instruction
// S_RUN      | normal execution, sources are sampled here
// S_WAIT_SF  | decode stalled until the status-flag request is satisfied
// S_WAIT_INT | WAI: sleeping until rst, NMI or a live IRQ
// S_STOP     | STP: only rst wakes the core
module cpu_int_ctrl #(
    parameter int          N_IRQ    = 4,
    parameter logic [15:0] VEC_BASE = 16'hFFE0,
    parameter logic [15:0] IR_RST   = 16'h132C,
    parameter logic [15:0] IR_INT   = 16'h8322
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             rst,
    input  logic             nmi,
    input  logic             brk,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             op_wai,
    input  logic             op_stp,
    input  logic             op_rti,
    input  logic             op_sei,
    input  logic             op_cli,
    input  logic             ex_free_slot,
    input  logic             sf_query,
    input  logic             sf_busy,
    input  logic             sf_rdy,
    output logic [15:0]      int_ir,
    output logic [15:0]      int_k,
    output logic             replace_ir,
    output logic             replace_k,
    output logic             hold_fetch,
    output logic             hold_decode,
    output logic             nmi_ack,
    output logic [N_IRQ-1:0] irq_ack
);

    typedef enum logic [2:0] {
        S_RESET,
        S_VECTOR,
        S_SKIP,
        S_RUN,
        S_WAIT_SF,
        S_WAIT_INT,
        S_STOP
    } state_t;

    localparam logic [3:0] SLOT_RST  = 4'd0;
    localparam logic [3:0] SLOT_NMI  = 4'd1;
    localparam logic [3:0] SLOT_BRK  = 4'd2;
    localparam logic [3:0] SLOT_IRQ0 = 4'd3;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       slot;
    logic [3:0]       slot_nxt;
    logic             i_mask;
    logic             nmi_prev;
    logic             nmi_pend;
    logic             nmi_edge;
    logic             sf_status;
    logic [N_IRQ-1:0] irq_live;
    logic             irq_any;
    logic [3:0]       irq_slot;
    logic [3:0]       run_slot;
    logic [3:0]       wait_slot;
    logic             any_pend;
    logic             enter_vec;

    assign nmi_edge = nmi & ~nmi_prev;
    assign irq_live = irq & irq_en & {N_IRQ{~i_mask}};
    assign irq_any  = |irq_live;
    assign any_pend = rst | nmi_pend | brk | irq_any;

    // Lowest-numbered live line wins; scanning downward lets it overwrite.
    always_comb begin
        irq_slot = SLOT_IRQ0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_live[i]) irq_slot = SLOT_IRQ0 + 4'(i);
        end
    end

    always_comb begin
        if (rst)           run_slot = SLOT_RST;
        else if (nmi_pend) run_slot = SLOT_NMI;
        else if (brk)      run_slot = SLOT_BRK;
        else               run_slot = irq_slot;
    end

    // WAI wakes on everything except a software break.
    always_comb begin
        if (rst)           wait_slot = SLOT_RST;
        else if (nmi_pend) wait_slot = SLOT_NMI;
        else               wait_slot = irq_slot;
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        case (state)
            S_RESET: begin
                state_nxt = S_VECTOR;
                slot_nxt  = SLOT_RST;
            end
            S_VECTOR: begin
                if (ex_free_slot) state_nxt = S_SKIP;
            end
            S_SKIP: begin
                if (ex_free_slot) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (sf_status && sf_query) begin
                    state_nxt = S_WAIT_SF;
                end else if (any_pend && ex_free_slot) begin
                    state_nxt = S_VECTOR;
                    slot_nxt  = run_slot;
                end else if (op_stp) begin
                    state_nxt = S_STOP;
                end else if (op_wai) begin
                    state_nxt = S_WAIT_INT;
                end
            end
            S_WAIT_SF: begin
                if (sf_rdy) state_nxt = S_RUN;
            end
            S_WAIT_INT: begin
                if (rst || nmi_pend || irq_any) begin
                    state_nxt = S_VECTOR;
                    slot_nxt  = wait_slot;
                end
            end
            S_STOP: begin
                if (rst) begin
                    state_nxt = S_VECTOR;
                    slot_nxt  = SLOT_RST;
                end
            end
            default: begin
                state_nxt = S_RESET;
                slot_nxt  = SLOT_RST;
            end
        endcase
        if (rst && state != S_RESET) begin
            state_nxt = S_VECTOR;
            slot_nxt  = SLOT_RST;
        end
    end

    // A sync reset while already in VECTOR counts as a fresh entry.
    assign enter_vec = (state_nxt == S_VECTOR) && ((state != S_VECTOR) || rst);

    always_comb begin
        nmi_ack = enter_vec && (slot_nxt == SLOT_NMI);
        irq_ack = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            irq_ack[i] = enter_vec && (slot_nxt == SLOT_IRQ0 + 4'(i));
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state     <= S_RESET;
            slot      <= SLOT_RST;
            i_mask    <= 1'b1;
            nmi_prev  <= 1'b0;
            nmi_pend  <= 1'b0;
            sf_status <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            nmi_prev <= nmi;
            nmi_pend <= nmi_edge | (nmi_pend & ~nmi_ack);
            if (enter_vec || op_sei)     i_mask <= 1'b1;
            else if (op_rti || op_cli)   i_mask <= 1'b0;
            if (sf_status) sf_status <= ~sf_rdy | sf_busy;
            else           sf_status <= sf_busy;
        end
    end

    assign int_k       = VEC_BASE + {11'd0, slot, 1'b0};
    assign int_ir      = (slot == SLOT_RST) ? IR_RST : IR_INT;
    assign replace_ir  = (state == S_VECTOR);
    assign replace_k   = (state == S_VECTOR);
    assign hold_fetch  = (state_nxt != S_RUN);
    assign hold_decode = (state_nxt != S_VECTOR) && (state_nxt != S_RUN);

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed bench for cpu_int_ctrl: a scoreboard checks each vector entry
// (instruction, argument, acknowledge) while the sequence checks the holds.
module tb_cpu_int_ctrl;

    logic        clk = 1'b0;
    logic        a_rst, rst, nmi, brk;
    logic [3:0]  irq, irq_en;
    logic        op_wai, op_stp, op_rti, op_sei, op_cli;
    logic        ex_free_slot, sf_query, sf_busy, sf_rdy;
    logic [15:0] int_ir, int_k;
    logic        replace_ir, replace_k, hold_fetch, hold_decode, nmi_ack;
    logic [3:0]  irq_ack;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] k;
        logic [4:0]  ack;
    } exp_t;

    exp_t sb[$];

    cpu_int_ctrl #(.N_IRQ(4)) dut (
        .clk(clk), .a_rst(a_rst), .rst(rst), .nmi(nmi), .brk(brk),
        .irq(irq), .irq_en(irq_en),
        .op_wai(op_wai), .op_stp(op_stp), .op_rti(op_rti), .op_sei(op_sei), .op_cli(op_cli),
        .ex_free_slot(ex_free_slot), .sf_query(sf_query), .sf_busy(sf_busy), .sf_rdy(sf_rdy),
        .int_ir(int_ir), .int_k(int_k), .replace_ir(replace_ir), .replace_k(replace_k),
        .hold_fetch(hold_fetch), .hold_decode(hold_decode), .nmi_ack(nmi_ack), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic ne();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] ir, input logic [15:0] k, input logic [4:0] ack);
        exp_t e;
        e.ir = ir;
        e.k = k;
        e.ack = ack;
        sb.push_back(e);
    endtask

    // Monitor: every new VECTOR entry is checked against the next queued
    // expectation; the ack must have been seen in the cycle just before.
    logic       rep_prev = 1'b0;
    logic [4:0] ack_prev = 5'd0;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (replace_ir === 1'b1 && rep_prev !== 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL vec_unexpected: got ir=%h k=%h, required no entry", int_ir, int_k);
            end else begin
                mon_e = sb.pop_front();
                if ({int_ir, int_k, ack_prev} !== {mon_e.ir, mon_e.k, mon_e.ack}) begin
                    n_fail++;
                    $display("FAIL vec_entry: got ir=%h k=%h ack=%b, required ir=%h k=%h ack=%b",
                             int_ir, int_k, ack_prev, mon_e.ir, mon_e.k, mon_e.ack);
                end
            end
        end
        rep_prev = replace_ir;
        ack_prev = {nmi_ack, irq_ack};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; rst = 1'b0; nmi = 1'b0; brk = 1'b0;
        irq = 4'd0; irq_en = 4'd0;
        op_wai = 1'b0; op_stp = 1'b0; op_rti = 1'b0; op_sei = 1'b0; op_cli = 1'b0;
        ex_free_slot = 1'b1; sf_query = 1'b0; sf_busy = 1'b0; sf_rdy = 1'b0;

        // reset values
        ne();
        chk("rst_hold_fetch", 32'(hold_fetch), 32'd1);
        chk("rst_hold_decode", 32'(hold_decode), 32'd0);
        chk("rst_acks", 32'({nmi_ack, irq_ack}), 32'd0);
        chk("rst_replace", 32'(replace_ir), 32'd0);
        chk("rst_int_k", 32'(int_k), 32'hFFE0);
        chk("rst_int_ir", 32'(int_ir), 32'h132C);
        nc();
        push(16'h132C, 16'hFFE0, 5'b00000);
        a_rst = 1'b0;

        // release: VECTOR, SKIP, RUN
        nc(); ne();
        chk("vec_replace", 32'(replace_ir), 32'd1);
        chk("vec_replace_k", 32'(replace_k), 32'd1);
        chk("vec_hold_fetch", 32'(hold_fetch), 32'd1);
        chk("vec_hold_decode", 32'(hold_decode), 32'd1);
        nc(); ne();
        chk("skip_replace", 32'(replace_ir), 32'd0);
        chk("skip_hold_fetch", 32'(hold_fetch), 32'd0);
        nc(); ne();
        chk("run_hold_fetch", 32'(hold_fetch), 32'd0);
        chk("run_hold_decode", 32'(hold_decode), 32'd0);

        // IRQ priority: lines 1 and 2 live, line 1 wins
        nc(); op_cli = 1'b1;
        nc(); op_cli = 1'b0; irq = 4'b0110; irq_en = 4'b1111;
        push(16'h8322, 16'hFFE8, 5'b00010);
        ne();
        chk("irq1_ack", 32'({nmi_ack, irq_ack}), 32'b00010);
        nc(); irq = 4'd0;
        ne();
        chk("irq1_ack_once", 32'({nmi_ack, irq_ack}), 32'd0);
        chk("irq1_int_k", 32'(int_k), 32'hFFE8);
        nc(); nc();
        irq = 4'b0001;
        ne();
        chk("masked_run", 32'(hold_fetch), 32'd0);
        chk("masked_ack", 32'({nmi_ack, irq_ack}), 32'd0);

        // NMI edge together with irq[0]: NMI taken, irq[0] waits for RTI
        nc(); nmi = 1'b1;
        ne();
        chk("nmi_edge_cycle", 32'({nmi_ack, irq_ack}), 32'd0);
        push(16'h8322, 16'hFFE2, 5'b10000);
        nc(); ne();
        chk("nmi_ack", 32'({nmi_ack, irq_ack}), 32'b10000);
        nc(); nc(); nc(); ne();
        chk("irq0_blocked", 32'({nmi_ack, irq_ack}), 32'd0);
        chk("irq0_blocked_run", 32'(hold_fetch), 32'd0);
        nc(); op_rti = 1'b1;
        ne();
        chk("rti_cycle", 32'({nmi_ack, irq_ack}), 32'd0);
        nc(); op_rti = 1'b0;
        push(16'h8322, 16'hFFE6, 5'b00001);
        ne();
        chk("irq0_after_rti", 32'({nmi_ack, irq_ack}), 32'b00001);
        nc(); irq = 4'd0; nmi = 1'b0;
        nc(); nc();

        // WAI with masked line, brk ignored, then enable
        nc(); op_wai = 1'b1; op_cli = 1'b1;
        ne();
        chk("wai_hold_decode", 32'(hold_decode), 32'd1);
        nc(); op_wai = 1'b0; op_cli = 1'b0; irq = 4'b0001; irq_en = 4'b0000; brk = 1'b1;
        ne();
        chk("wai_brk_ignored", 32'(hold_decode), 32'd1);
        chk("wai_brk_ack", 32'({nmi_ack, irq_ack}), 32'd0);
        nc(); brk = 1'b0;
        ne();
        chk("wai_masked", 32'(hold_decode), 32'd1);
        nc(); irq_en = 4'b0001;
        push(16'h8322, 16'hFFE6, 5'b00001);
        ne();
        chk("wai_wake_ack", 32'({nmi_ack, irq_ack}), 32'b00001);
        chk("wai_wake_decode", 32'(hold_decode), 32'd0);
        nc(); irq = 4'd0; irq_en = 4'b1111;
        nc(); nc();

        // STP ignores nmi and brk, exits only on rst; the NMI stays pending
        nc(); op_stp = 1'b1;
        ne();
        chk("stp_hold_decode", 32'(hold_decode), 32'd1);
        nc(); op_stp = 1'b0; nmi = 1'b1; brk = 1'b1;
        ne();
        chk("stop_hold1", 32'(hold_decode), 32'd1);
        nc(); ne();
        chk("stop_hold2", 32'(hold_decode), 32'd1);
        chk("stop_ack", 32'({nmi_ack, irq_ack}), 32'd0);
        nc(); rst = 1'b1;
        push(16'h132C, 16'hFFE0, 5'b00000);
        ne();
        chk("stop_rst_decode", 32'(hold_decode), 32'd0);
        chk("stop_rst_ack", 32'({nmi_ack, irq_ack}), 32'd0);
        nc(); rst = 1'b0; brk = 1'b0; nmi = 1'b0;
        ne();
        chk("stop_rst_ir", 32'(int_ir), 32'h132C);
        push(16'h8322, 16'hFFE2, 5'b10000);
        nc(); nc(); ne();
        chk("nmi_retained", 32'({nmi_ack, irq_ack}), 32'b10000);
        nc(); nc(); nc();

        // BRK waits for a free slot; VECTOR stalls without one
        nc(); ex_free_slot = 1'b0; brk = 1'b1;
        ne();
        chk("brk_nofree", 32'(hold_fetch), 32'd0);
        nc(); ex_free_slot = 1'b1;
        push(16'h8322, 16'hFFE4, 5'b00000);
        ne();
        chk("brk_go_fetch", 32'(hold_fetch), 32'd1);
        chk("brk_go_decode", 32'(hold_decode), 32'd0);
        nc(); brk = 1'b0; ex_free_slot = 1'b0;
        ne();
        chk("vec_stall_decode", 32'(hold_decode), 32'd0);
        chk("vec_stall_fetch", 32'(hold_fetch), 32'd1);
        nc(); ne();
        chk("vec_stall_replace", 32'(replace_ir), 32'd1);
        ex_free_slot = 1'b1;
        nc(); nc();

        // status-flag wait
        nc(); sf_busy = 1'b1;
        nc(); sf_busy = 1'b0; sf_query = 1'b1;
        ne();
        chk("sf_query_decode", 32'(hold_decode), 32'd1);
        chk("sf_query_fetch", 32'(hold_fetch), 32'd1);
        nc(); sf_query = 1'b0;
        ne();
        chk("wait_sf_hold", 32'(hold_decode), 32'd1);
        nc(); sf_rdy = 1'b1;
        ne();
        chk("sf_rdy_fetch", 32'(hold_fetch), 32'd0);
        chk("sf_rdy_decode", 32'(hold_decode), 32'd0);
        nc(); sf_rdy = 1'b0; sf_query = 1'b1;
        ne();
        chk("sf_cleared", 32'(hold_fetch), 32'd0);
        nc(); sf_query = 1'b0;

        nc(); nc(); ne();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_int_ctrl.md
CPU_INT_CTRL -- requirements
Module: cpu_int_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4: number of maskable IRQ lines; legal range 1..13.
REQ-002 Parameter VEC_BASE, default 16'hFFE0: base address of the vector table.
REQ-003 Parameter IR_RST, default 16'h132C: instruction injected for reset entry.
REQ-004 Parameter IR_INT, default 16'h8322: instruction injected for non-reset entry.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 a_rst  in  1  asynchronous, active-high reset.
REQ-007 rst, nmi, brk  in  1 each  synchronous reset request, non-maskable interrupt, and software break.
REQ-008 irq  in  N_IRQ  level-sensitive interrupt requests.
REQ-009 irq_en  in  N_IRQ  per-line enables; 1 = line enabled.
REQ-010 op_wai, op_stp, op_rti, op_sei, op_cli  in  1 each  decoded opcode strobes.
REQ-011 ex_free_slot  in  1  back end can accept an issued opcode this cycle.
REQ-012 sf_query, sf_busy, sf_rdy  in  1 each  status-flag request, busy set, and busy clear.
REQ-013 int_ir, int_k  out  16 each  injected instruction and argument.
REQ-014 replace_ir, replace_k, hold_fetch, hold_decode  out  1 each  front-end control.
REQ-015 nmi_ack  out  1  and  irq_ack  out  N_IRQ  one-hot acknowledge pulses.

Function
REQ-016 States: RESET, VECTOR, SKIP, RUN, WAIT_SF, WAIT_INT, STOP.
REQ-017 sf_status register: when 0, next value is sf_busy; when 1, next value is (~sf_rdy | sf_busy).
REQ-018 Global mask I: set on any entry to VECTOR and on op_sei; cleared on op_rti or op_cli; op_sei wins on conflict; reset value 1.
REQ-019 NMI is edge-triggered: a 0->1 transition of nmi sets nmi_pend; nmi_pend clears in the cycle nmi_ack pulses; an edge coincident with the ack cycle is retained.
REQ-020 irq_live[i] = irq[i] & irq_en[i] & ~I.
REQ-021 Source priority is rst > nmi_pend > brk > irq_live, lowest index first.
REQ-022 Slot numbers: RST=0, NMI=1, BRK=2, IRQ i = 3+i.
REQ-023 int_k = VEC_BASE + 2*slot, truncated to 16 bits (wraps modulo 2^16).
REQ-024 int_ir = IR_RST when the latched slot is 0, otherwise IR_INT.
REQ-025 Transition RESET->VECTOR is unconditional; slot = 0.
REQ-026 In VECTOR, the block goes to SKIP when ex_free_slot is high; otherwise it stays in VECTOR.
REQ-027 In SKIP, the block goes to RUN when ex_free_slot is high; otherwise it stays in SKIP.
REQ-028 From RUN, transitions are evaluated in this order:
- sf_status & sf_query -> WAIT_SF;
- any pending source & ex_free_slot -> VECTOR, latching the highest-priority slot;
- op_stp -> STOP;
- op_wai -> WAIT_INT;
- otherwise stay in RUN.
REQ-029 In WAIT_SF, the block goes to RUN when sf_rdy is high; otherwise it stays in WAIT_SF.
REQ-030 In WAIT_INT, rst, nmi_pend or any irq_live -> VECTOR, latching the winning slot; brk is ignored.
REQ-031 In STOP, only rst causes an exit -> VECTOR with slot 0.
REQ-032 rst high in any state other than RESET forces next state VECTOR with slot 0, regardless of ex_free_slot; this overrides REQ-026..031.
REQ-033 Acknowledge pulses:
- nmi_ack and irq_ack[i] pulse for exactly one cycle, combinationally, in the cycle the block transitions into VECTOR with slot 1 or slot 3+i respectively;
- at most one ack is high per cycle.
REQ-034 replace_ir = replace_k = (state == VECTOR).
REQ-035 hold_fetch = (next_state != RUN).
REQ-036 hold_decode = (next_state not in {VECTOR, RUN}).

Reset
REQ-037 While a_rst is high:
- state = RESET, sf_status = 0, I = 1, nmi_pend = 0, slot = 0;
- ack outputs = 0; hold_fetch = 1, hold_decode = 0.
REQ-038 After a_rst falls, the first rising edge moves the block to VECTOR with int_ir = 16'h132C and int_k = 16'hFFE0.

Verification
REQ-039 Scenario: release a_rst with ex_free_slot=1 -> VECTOR for 1 cycle (int_k=16'hFFE0), then SKIP, then RUN with hold_fetch=0.
REQ-040 Scenario: in RUN with I cleared by op_cli, assert irq=4'b0110, irq_en=4'b1111 -> irq_ack=4'b0010 for one cycle; int_k=16'hFFE8; I=1 afterwards.
REQ-041 Scenario: assert an nmi rising edge and irq[0] in the same cycle -> nmi_ack only, int_k=16'hFFE2; irq[0] is taken only after op_rti.
REQ-042 Scenario: op_wai, then raise a masked irq (irq_en=0) -> remains in WAIT_INT; then set irq_en=1 with I=0 -> VECTOR.
REQ-043 Scenario: op_stp, then nmi edge and brk -> remains in STOP; then rst -> VECTOR with int_ir=16'h132C.
REQ-044 Scenario: sf_busy pulse, then sf_query in RUN -> WAIT_SF with hold_decode=1; sf_rdy -> RUN on the next edge.
